// File: rtl/dlfloat_mac_seq.sv
// dlfloat_mac_seq: sequencer for the DLFloat16 multiply-accumulate datapath.
// It collects len operand pairs from the host, one 16-bit word per beat (A, then B).
// It clears the accumulator and issues each pair to the MAC. After the last pair it
// waits out the pipeline latency, captures the result and presents it under a
// valid/ready handshake.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_start, i_len            command pulse and pair count (sampled in idle only)
//   i_in_valid, i_in_data     host word stream; o_in_ready accepts a word
//   o_mac_a, o_mac_b          registered operands to the datapath
//   o_mac_en, o_acc_clr       one-cycle issue strobe and accumulator clear
//   i_mac_result              datapath accumulator value
//   o_out_valid, o_out_data   captured result; consumed with i_out_ready
//   o_busy                    high whenever the sequencer is not idle
module dlfloat_mac_seq #(
    parameter int unsigned MAC_LATENCY = 3,
    parameter int unsigned LEN_W       = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_in_valid,
    input  logic [15:0]      i_in_data,
    output logic             o_in_ready,
    output logic [15:0]      o_mac_a,
    output logic [15:0]      o_mac_b,
    output logic             o_mac_en,
    output logic             o_acc_clr,
    input  logic [15:0]      i_mac_result,
    output logic             o_out_valid,
    output logic [15:0]      o_out_data,
    input  logic             i_out_ready,
    output logic             o_busy
);

    localparam int unsigned DRAIN_W = $clog2(MAC_LATENCY + 2);
    // One extra edge past the latency so the sample lands after the result settles.
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(MAC_LATENCY + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StDrain,
        StDone
    } state_e;

    state_e             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [15:0]        r_op_a;
    logic [15:0]        r_mac_a;
    logic [15:0]        r_mac_b;
    logic               r_mac_en;
    logic               r_acc_clr;
    logic [15:0]        r_out_data;
    logic               w_accept;

    assign o_in_ready  = (r_state == StLoadA) || (r_state == StLoadB);
    assign o_out_valid = (r_state == StDone);
    assign o_busy      = (r_state != StIdle);
    assign o_mac_a     = r_mac_a;
    assign o_mac_b     = r_mac_b;
    assign o_mac_en    = r_mac_en;
    assign o_acc_clr   = r_acc_clr;
    assign o_out_data  = r_out_data;
    assign w_accept    = i_in_valid & o_in_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_remaining <= '0;
            r_drain_cnt <= '0;
            r_op_a      <= '0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_mac_en    <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_out_data  <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_mac_en  <= 1'b0;
            r_acc_clr <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            r_remaining <= i_len;
                            r_acc_clr   <= 1'b1;
                            r_state     <= StLoadA;
                        end else begin
                            r_out_data <= '0;
                            r_state    <= StDone;
                        end
                    end
                end
                StLoadA: begin
                    if (w_accept) begin
                        r_op_a  <= i_in_data;
                        r_state <= StLoadB;
                    end
                end
                StLoadB: begin
                    if (w_accept) begin
                        r_mac_a     <= r_op_a;
                        r_mac_b     <= i_in_data;
                        r_mac_en    <= 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == LEN_W'(1)) begin
                            r_drain_cnt <= DRAIN_INIT;
                            r_state     <= StDrain;
                        end else begin
                            r_state <= StLoadA;
                        end
                    end
                end
                StDrain: begin
                    r_drain_cnt <= r_drain_cnt - 1'b1;
                    if (r_drain_cnt == DRAIN_W'(1)) begin
                        r_out_data <= i_mac_result;
                        r_state    <= StDone;
                    end
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// tb_dlfloat_mac_seq: directed bench for dlfloat_mac_seq with a behavioural
// DLFloat16 MAC (1 sign, 6 exponent bias 31, 9 mantissa) of latency MAC_LATENCY.
// Inputs are driven and outputs sampled on the falling edge.
module tb_dlfloat_mac_seq;

    localparam int LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic        mac_en;
    logic        acc_clr;
    logic [15:0] mac_result;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int rise = 0;
    int clr_cnt = 0;
    int clr_cyc = 0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    int          q_c[$];
    logic [15:0] m_pipe[LAT];

    dlfloat_mac_seq #(.MAC_LATENCY(LAT), .LEN_W(4)) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_len        (len),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_mac_a      (mac_a),
        .o_mac_b      (mac_b),
        .o_mac_en     (mac_en),
        .o_acc_clr    (acc_clr),
        .i_mac_result (mac_result),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .i_out_ready  (out_ready),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real df2r(input logic [15:0] x);
        real m;
        int  e;
        e = int'(x[14:9]);
        if (e == 0) return 0.0;
        m = 1.0 + real'(int'(x[8:0])) / 512.0;
        while (e > 31) begin m = m * 2.0; e--; end
        while (e < 31) begin m = m / 2.0; e++; end
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2df(input real r);
        logic s;
        int   e;
        real  m;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 31;
        while (m >= 2.0 && e < 63) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > 1) begin m = m * 2.0; e--; end
        return {s, 6'(e), 9'($rtoi((m - 1.0) * 512.0))};
    endfunction

    // Behavioural MAC: accumulate on the edge that samples mac_en, then delay
    // so mac_result reflects the pair LAT edges after that sampling edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) m_pipe[i] <= 16'h0000;
        end else begin
            if (acc_clr) m_pipe[0] <= 16'h0000;
            else if (mac_en) m_pipe[0] <= r2df(df2r(m_pipe[0]) + df2r(mac_a) * df2r(mac_b));
            for (int i = 1; i < LAT; i++) m_pipe[i] <= m_pipe[i-1];
        end
    end
    assign mac_result = m_pipe[LAT-1];

    // Strobe monitor.
    always @(negedge clk) begin
        if (mac_en) begin
            q_a.push_back(mac_a);
            q_b.push_back(mac_b);
            q_c.push_back(cyc);
        end
        if (acc_clr) begin
            clr_cnt <= clr_cnt + 1;
            clr_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk);
        q_a.delete();
        q_b.delete();
        q_c.delete();
        clr_cnt = 0;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready", in_ready, 1);
        if (in_ready) begin
            @(posedge clk);
            @(negedge clk);
            last_acc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", out_valid, 1);
        rise = cyc;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("consume_valid", out_valid, 0);
        chk("consume_busy", busy, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {in_ready, mac_a, mac_b, mac_en, acc_clr, out_valid, out_data, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pair 1.0 * 2.0.
        clear_mon();
        do_start(4'd1);
        chk("busy_run", busy, 1);
        send_word(16'h3E00, 0);
        send_word(16'h4000, 0);
        wait_done();
        chk("p1_latency", rise - last_acc, 4);
        chk("p1_out", out_data, 16'h4000);
        chk("p1_clr_cnt", clr_cnt, 1);
        chk("p1_en_cnt", q_a.size(), 1);
        if (q_a.size() >= 1) begin
            chk("p1_a", q_a[0], 16'h3E00);
            chk("p1_b", q_b[0], 16'h4000);
            chk("p1_clr_gap", q_c[0] - clr_cyc, 2);
        end
        consume();

        // Three pairs of 1.0*1.0 with host gaps, then output backpressure.
        clear_mon();
        do_start(4'd3);
        for (int i = 0; i < 6; i++) send_word(16'h3E00, int'($urandom_range(0, 3)));
        wait_done();
        chk("p3_en_cnt", q_a.size(), 3);
        chk("p3_out", out_data, 16'h4100);
        for (int i = 0; i < 5; i++) begin
            start = (i == 1);
            len   = 4'd1;
            @(negedge clk);
            start = 1'b0;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 16'h4100);
        end
        consume();
        @(negedge clk);
        chk("bp_start_ignored", clr_cnt, 1);
        chk("bp_idle", busy, 0);

        // Pairing order: (2.0,1.0) then (1.0,4.0) -> 6.0.
        clear_mon();
        do_start(4'd2);
        send_word(16'h4000, 1);
        send_word(16'h3E00, 0);
        send_word(16'h3E00, 2);
        send_word(16'h4200, 1);
        wait_done();
        chk("p2_en_cnt", q_a.size(), 2);
        if (q_a.size() >= 2) begin
            chk("p2_a0", q_a[0], 16'h4000);
            chk("p2_b0", q_b[0], 16'h3E00);
            chk("p2_a1", q_a[1], 16'h3E00);
            chk("p2_b1", q_b[1], 16'h4200);
        end
        chk("p2_out", out_data, 16'h4300);
        consume();

        // Zero-length command.
        clear_mon();
        do_start(4'd0);
        chk("z_valid", out_valid, 1);
        chk("z_data", out_data, 16'h0000);
        consume();
        @(negedge clk);
        chk("z_clr_cnt", clr_cnt, 0);
        chk("z_en_cnt", q_a.size(), 0);

        // Maximum length, back-to-back words.
        clear_mon();
        do_start(4'd15);
        for (int i = 0; i < 30; i++) send_word(16'h3E00, 0);
        chk("max_ready_low", in_ready, 0);
        wait_done();
        chk("max_en_cnt", q_a.size(), 15);
        if (q_c.size() == 15) begin
            for (int i = 1; i < 15; i++) chk("max_spacing", q_c[i] - q_c[i-1], 2);
        end
        chk("max_out", out_data, 16'h45C0);
        consume();

        // Reset in the middle of LOAD_B of a len=3 run.
        clear_mon();
        do_start(4'd3);
        send_word(16'h3E00, 0);
        send_word(16'h3E00, 0);
        send_word(16'h3E00, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_reset_outs",
            {in_ready, mac_a, mac_b, mac_en, acc_clr, out_valid, out_data, busy}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_reset_idle", {out_valid, busy}, 0);
        clear_mon();
        do_start(4'd1);
        send_word(16'h4000, 0);
        send_word(16'h4000, 0);
        wait_done();
        chk("post_reset_out", out_data, 16'h4200);
        chk("post_reset_en", q_a.size(), 1);
        consume();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dlfloat_mac_seq.md
Name: dlfloat_mac_seq

Overview:
- Sequencer for the DLFloat16 multiply-accumulate datapath behind the 16-bit pin bus.
- Collects N operand pairs from the host one 16-bit word per beat, A word then B word.
- Clears the accumulator, issues each pair to the MAC, then waits the fixed pipeline latency.
- Captures the final accumulated result and presents it with a valid/ready handshake.
- Replaces the free-running two-phase capture: the host gets explicit ready, length control and a completion signal.

Parameters:
- MAC_LATENCY, 3: edges from the datapath sampling mac_en until mac_result reflects that pair.
- LEN_W, 4: width of the pair-count field; maximum vector length is 2^LEN_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- len  in  LEN_W  number of operand pairs; sampled with start
- in_valid  in  1  host word valid
- in_data  in  16  host word (DLFloat16)
- in_ready  out  1  controller accepts a word this cycle
- mac_a  out  16  operand A to datapath (registered)
- mac_b  out  16  operand B to datapath (registered)
- mac_en  out  1  one-cycle pair-issue strobe (registered)
- acc_clr  out  1  one-cycle accumulator clear (registered)
- mac_result  in  16  datapath accumulator value
- out_valid  out  1  result valid
- out_data  out  16  captured result
- out_ready  in  1  host consumes result
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset, sampled on a rising edge with rst_n=0:
  - State goes to IDLE; all counters clear.
  - Every output goes to 0: in_ready, mac_a, mac_b, mac_en, acc_clr, out_valid, out_data, busy.
  - Reset mid-operation abandons the vector; no partial result is presented.
- A word is accepted on an edge where in_valid & in_ready are both 1. in_ready is combinational from state only.
- States: IDLE, LOAD_A, LOAD_B, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 with len!=0: load remaining=len, pulse acc_clr for the next cycle, go to LOAD_A.
  - start=1 with len=0: set out_data=0 and go to DONE. acc_clr and mac_en are not pulsed.
- LOAD_A:
  - in_ready=1.
  - On accept: hold the word in op_a_q and go to LOAD_B.
- LOAD_B:
  - in_ready=1.
  - On accept, at that same edge:
    - mac_a<=op_a_q, mac_b<=in_data, mac_en<=1 for exactly one cycle;
    - remaining decrements.
  - remaining was 1: load drain_cnt=MAC_LATENCY+1 and go to DRAIN. Otherwise go to LOAD_A.
- mac_a/mac_b hold their last issued values between issues. The minimum issue spacing is 2 cycles.
- DRAIN:
  - in_ready=0; drain_cnt decrements each edge.
  - On the edge where drain_cnt==1: out_data<=mac_result, go to DONE.
  - So out_data samples mac_result exactly MAC_LATENCY+1 edges after the final B accept.
- DONE:
  - out_valid=1; out_data is held stable.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
  - out_ready already high on entry: a 1-cycle out_valid pulse.
- Ignored inputs:
  - start outside IDLE has no effect.
  - in_valid in IDLE, DRAIN or DONE is not accepted, and in_ready stays 0.
- acc_clr and the first mac_en never coincide. The earliest first mac_en is 2 cycles after acc_clr.
- Host stalls of any length (in_valid=0) in LOAD_A or LOAD_B are legal; state and operands are held.
- Maximum len (2^LEN_W-1) issues exactly that many mac_en pulses; the pair counter never wraps.

Test Plan:
- Reset with MAC_LATENCY=3: assert rst_n=0 for 2 edges in the middle of LOAD_B of a len=3 run -> all outputs 0, state IDLE, no out_valid. A following start len=1 then runs normally.
- Single pair: start len=1, words 0x3E00 (1.0) then 0x4000 (2.0), bench MAC model -> sequence is as follows:
  - acc_clr pulses once;
  - then one mac_en with mac_a=0x3E00, mac_b=0x4000;
  - out_data=0x4000, out_valid rises 4 edges after the B accept.
- Vector len=3 with host gaps: random in_valid=0 cycles between words -> exactly 3 mac_en pulses in order with correct A/B pairing. Pairs (0x3E00,0x3E00) x3 give out_data=0x4100 (3.0).
- len=0 start -> DONE on the next edge with out_data=0x0000, no acc_clr, no mac_en.
- Output backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_data stable. start pulses during DONE are ignored. out_ready=1 returns to IDLE with busy=0 the next cycle.
- len=15 (LEN_W=4): back-to-back words -> exactly 15 mac_en pulses, each 2 cycles apart, and in_ready low after the 30th word.
